// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger and its consumers.
// The master side drives enable and the raw sensor echo; the slave (the ranger)
// drives the trigger pulse and the measurement results.
interface ultrasonic_ranger_if #(
    parameter int CNT_W = 22
);
    logic             en;
    logic             echo;
    logic             trig;
    logic [1:0]       level;
    logic             level_valid;
    logic [CNT_W-1:0] echo_cycles;
    logic             fault;

    modport master (
        output en,
        output echo,
        input  trig,
        input  level,
        input  level_valid,
        input  echo_cycles,
        input  fault
    );

    modport slave (
        input  en,
        input  echo,
        output trig,
        output level,
        output level_valid,
        output echo_cycles,
        output fault
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger front end for the tank level controller.
// Fires periodic trigger pulses, times the synchronised echo width, quantises it
// into a 2-bit level code (0 = empty .. 3 = full) and only changes the reported
// level after CONFIRM equal consecutive readings. A missing or stuck echo raises
// a sticky fault that clears on the next good measurement.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES  = 500,
    parameter int MEAS_PERIOD  = 3000000,
    parameter int ECHO_TIMEOUT = 1900000,
    parameter int TH_FULL      = 15000,
    parameter int TH_HIGH      = 40000,
    parameter int TH_MID       = 80000,
    parameter int CONFIRM      = 2,
    parameter int CNT_W        = 22
) (
    input  logic                clk,
    input  logic                rst,
    ultrasonic_ranger_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_PERIOD - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TH_FULL_C = CNT_W'(TH_FULL);
    localparam logic [CNT_W-1:0] TH_HIGH_C = CNT_W'(TH_HIGH);
    localparam logic [CNT_W-1:0] TH_MID_C  = CNT_W'(TH_MID);
    localparam logic [7:0]       CONFIRM_C = 8'(CONFIRM);

    logic [2:0]       state_q, state_d;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] tout_q, tout_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
    logic [1:0]       level_q, level_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [1:0]       cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sync1_q, sync2_q, sync3_q;

    logic             echo_rise;
    logic             echo_fall;
    logic [1:0]       width_class;

    assign echo_rise = sync2_q & ~sync3_q;
    assign echo_fall = ~sync2_q & sync3_q;

    // Quantise the measured width; a width equal to a threshold falls to the lower level
    always_comb begin
        width_class = 2'd0;
        if (width_q < TH_FULL_C) begin
            width_class = 2'd3;
        end else if (width_q < TH_HIGH_C) begin
            width_class = 2'd2;
        end else if (width_q < TH_MID_C) begin
            width_class = 2'd1;
        end
    end

    // Next-state logic for the ranging sequence, timeout handling and level filter
    always_comb begin
        state_d       = state_q;
        trig_d        = trig_q;
        period_d      = period_q;
        tout_d        = tout_q;
        width_d       = width_q;
        echo_cycles_d = echo_cycles_q;
        level_d       = level_q;
        valid_d       = 1'b0;
        fault_d       = fault_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;

        if (state_q != S_IDLE) begin
            period_d = period_q + 1'b1;
        end

        if (!bus.en) begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_TRIG;
                    trig_d   = 1'b1;
                    period_d = '0;
                end
                S_TRIG: begin
                    if (period_q == TRIG_LAST) begin
                        state_d = S_WAIT;
                        trig_d  = 1'b0;
                        tout_d  = '0;
                    end
                end
                S_WAIT: begin
                    tout_d = tout_q + 1'b1;
                    if (tout_q == TOUT_LAST) begin
                        state_d = S_HOLDOFF;
                        fault_d = 1'b1;
                    end else if (echo_rise) begin
                        state_d = S_MEASURE;
                        width_d = CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    tout_d = tout_q + 1'b1;
                    if (echo_fall) begin
                        state_d       = S_HOLDOFF;
                        echo_cycles_d = width_q;
                        valid_d       = 1'b1;
                        fault_d       = 1'b0;
                        if (width_class == cand_q) begin
                            if (cnt_q < CONFIRM_C) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else begin
                            cand_d = width_class;
                            cnt_d  = 8'd1;
                        end
                        if (cnt_d >= CONFIRM_C) begin
                            level_d = cand_d;
                        end
                    end else if (tout_q == TOUT_LAST) begin
                        state_d = S_HOLDOFF;
                        fault_d = 1'b1;
                    end else if (sync2_q && (width_q != {CNT_W{1'b1}})) begin
                        width_d = width_q + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (period_q >= MEAS_LAST) begin
                        state_d  = S_TRIG;
                        trig_d   = 1'b1;
                        period_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    trig_d  = 1'b0;
                end
            endcase
        end
    end

    // Two-flop echo synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.echo;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // State, counters, results and filter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            trig_q        <= 1'b0;
            period_q      <= '0;
            tout_q        <= '0;
            width_q       <= '0;
            echo_cycles_q <= '0;
            level_q       <= 2'd0;
            valid_q       <= 1'b0;
            fault_q       <= 1'b0;
            cand_q        <= 2'd0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            trig_q        <= trig_d;
            period_q      <= period_d;
            tout_q        <= tout_d;
            width_q       <= width_d;
            echo_cycles_q <= echo_cycles_d;
            level_q       <= level_d;
            valid_q       <= valid_d;
            fault_q       <= fault_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.trig        = trig_q;
    assign bus.level       = level_q;
    assign bus.level_valid = valid_q;
    assign bus.echo_cycles = echo_cycles_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed testbench for ultrasonic_ranger using small timing parameters.
module tb_ultrasonic_ranger;

    localparam int CNT_W = 12;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ultrasonic_ranger_if #(.CNT_W(CNT_W)) dutIf ();

    ultrasonic_ranger #(
        .TRIG_CYCLES (4),
        .MEAS_PERIOD (200),
        .ECHO_TIMEOUT(150),
        .TH_FULL     (20),
        .TH_HIGH     (40),
        .TH_MID      (60),
        .CONFIRM     (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dutIf.slave)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waits for a trigger pulse, then drives an echo of the given width and
    // watches for the resulting valid pulse
    task automatic do_echo(input int width, output bit sawValid);
        int k;
        sawValid = 1'b0;
        k = 0;
        while (dutIf.trig !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (dutIf.trig !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        dutIf.echo = 1'b1;
        repeat (width) @(negedge clk);
        dutIf.echo = 1'b0;
        k = 0;
        while (!sawValid && k < 10) begin
            @(negedge clk);
            if (dutIf.level_valid === 1'b1) sawValid = 1'b1;
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dutIf.en = 1'b0;
        dutIf.echo = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dutIf.trig !== 1'b0) begin bad++; $display("[TB] FAIL reset_trig: got %0d expected 0", dutIf.trig); end
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", dutIf.level); end
        total++;
        if (dutIf.level_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0d expected 0", dutIf.level_valid); end
        total++;
        if (dutIf.echo_cycles !== '0) begin bad++; $display("[TB] FAIL reset_echo_cycles: got %0d expected 0", dutIf.echo_cycles); end
        total++;
        if (dutIf.fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %0d expected 0", dutIf.fault); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start();
        int highCnt;
        int periodCnt;
        dutIf.en = 1'b1;
        @(negedge clk);
        total++;
        if (dutIf.trig !== 1'b1) begin bad++; $display("[TB] FAIL start_trig_rise: got %0d expected 1", dutIf.trig); end
        highCnt = 1;
        periodCnt = 0;
        while (dutIf.trig === 1'b1 && periodCnt < 20) begin
            @(negedge clk);
            periodCnt++;
            if (dutIf.trig === 1'b1) highCnt++;
        end
        total++;
        if (highCnt != 4) begin bad++; $display("[TB] FAIL start_trig_width: got %0d expected 4", highCnt); end
        while (dutIf.trig !== 1'b1 && periodCnt < 400) begin
            @(negedge clk);
            periodCnt++;
        end
        total++;
        if (periodCnt != 200) begin bad++; $display("[TB] FAIL start_period: got %0d expected 200", periodCnt); end
    endtask

    task automatic test_basic();
        bit v;
        do_echo(10, v);
        total++;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid1: got %0d expected 1", v); end
        total++;
        if (dutIf.echo_cycles !== 12'd10) begin bad++; $display("[TB] FAIL basic_cycles1: got %0d expected 10", dutIf.echo_cycles); end
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL basic_level1: got %0d expected 0", dutIf.level); end
        total++;
        if (dutIf.fault !== 1'b0) begin bad++; $display("[TB] FAIL basic_fault_clear: got %0d expected 0", dutIf.fault); end
        do_echo(10, v);
        total++;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid2: got %0d expected 1", v); end
        total++;
        if (dutIf.echo_cycles !== 12'd10) begin bad++; $display("[TB] FAIL basic_cycles2: got %0d expected 10", dutIf.echo_cycles); end
        total++;
        if (dutIf.level !== 2'd3) begin bad++; $display("[TB] FAIL basic_level2: got %0d expected 3", dutIf.level); end
    endtask

    task automatic test_filter();
        bit v;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_echo(50, v);
        total++;
        if (v !== 1'b1 || dutIf.echo_cycles !== 12'd50) begin bad++; $display("[TB] FAIL filter_50_cycles: got %0d valid %0d expected 50 valid 1", dutIf.echo_cycles, v); end
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL filter_after_50: got %0d expected 0", dutIf.level); end
        do_echo(10, v);
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL filter_after_10a: got %0d expected 0", dutIf.level); end
        do_echo(10, v);
        total++;
        if (dutIf.level !== 2'd3) begin bad++; $display("[TB] FAIL filter_after_10b: got %0d expected 3", dutIf.level); end
    endtask

    task automatic test_boundary();
        bit v;
        do_echo(20, v);
        total++;
        if (dutIf.echo_cycles !== 12'd20) begin bad++; $display("[TB] FAIL bound_20_cycles: got %0d expected 20", dutIf.echo_cycles); end
        total++;
        if (dutIf.level !== 2'd3) begin bad++; $display("[TB] FAIL bound_20_first: got %0d expected 3", dutIf.level); end
        do_echo(20, v);
        total++;
        if (dutIf.level !== 2'd2) begin bad++; $display("[TB] FAIL bound_20: got %0d expected 2", dutIf.level); end
        do_echo(60, v);
        do_echo(60, v);
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL bound_60: got %0d expected 0", dutIf.level); end
        do_echo(19, v);
        do_echo(19, v);
        total++;
        if (dutIf.level !== 2'd3) begin bad++; $display("[TB] FAIL bound_19: got %0d expected 3", dutIf.level); end
    endtask

    task automatic test_timeout();
        int k;
        bit sawValid;
        bit v;
        sawValid = 1'b0;
        k = 0;
        while (dutIf.trig !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        k = 0;
        while (dutIf.trig !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (dutIf.fault !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
            if (dutIf.level_valid === 1'b1) sawValid = 1'b1;
        end
        total++;
        if (k != 150) begin bad++; $display("[TB] FAIL timeout_latency: got %0d expected 150", k); end
        total++;
        if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL timeout_no_valid: got %0d expected 0", sawValid); end
        total++;
        if (dutIf.level !== 2'd3) begin bad++; $display("[TB] FAIL timeout_level_held: got %0d expected 3", dutIf.level); end
        total++;
        if (dutIf.echo_cycles !== 12'd19) begin bad++; $display("[TB] FAIL timeout_cycles_held: got %0d expected 19", dutIf.echo_cycles); end
        do_echo(10, v);
        total++;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL recover_valid: got %0d expected 1", v); end
        total++;
        if (dutIf.fault !== 1'b0) begin bad++; $display("[TB] FAIL recover_fault: got %0d expected 0", dutIf.fault); end
    endtask

    task automatic test_reset_mid();
        int k;
        bit v;
        k = 0;
        while (dutIf.trig !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        k = 0;
        while (dutIf.trig !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        dutIf.echo = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (dutIf.trig !== 1'b0 || dutIf.level !== 2'd0 || dutIf.fault !== 1'b0 || dutIf.level_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got trig %0d level %0d fault %0d valid %0d expected all 0", dutIf.trig, dutIf.level, dutIf.fault, dutIf.level_valid);
        end
        total++;
        if (dutIf.echo_cycles !== '0) begin bad++; $display("[TB] FAIL midreset_cycles: got %0d expected 0", dutIf.echo_cycles); end
        dutIf.echo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_echo(30, v);
        total++;
        if (v !== 1'b1 || dutIf.echo_cycles !== 12'd30) begin bad++; $display("[TB] FAIL midreset_restart: got %0d valid %0d expected 30 valid 1", dutIf.echo_cycles, v); end
        total++;
        if (dutIf.level !== 2'd0) begin bad++; $display("[TB] FAIL midreset_level: got %0d expected 0", dutIf.level); end
    endtask

    task automatic test_en_drop();
        int k;
        int highCnt;
        k = 0;
        while (dutIf.trig !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        total++;
        if (dutIf.trig !== 1'b1) begin bad++; $display("[TB] FAIL endrop_trig_seen: got %0d expected 1", dutIf.trig); end
        dutIf.en = 1'b0;
        @(negedge clk);
        total++;
        if (dutIf.trig !== 1'b0) begin bad++; $display("[TB] FAIL endrop_trig_low: got %0d expected 0", dutIf.trig); end
        dutIf.en = 1'b1;
        @(negedge clk);
        highCnt = 0;
        k = 0;
        while (dutIf.trig === 1'b1 && k < 20) begin
            highCnt++;
            @(negedge clk);
            k++;
        end
        total++;
        if (highCnt != 4) begin bad++; $display("[TB] FAIL endrop_restart_width: got %0d expected 4", highCnt); end
    endtask

    // Runs every scenario in order, then prints the summary
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        dutIf.en = 1'b0;
        dutIf.echo = 1'b0;
        $display("[TB] starting ultrasonic_ranger bench");
        test_reset();
        test_start();
        test_basic();
        test_filter();
        test_boundary();
        test_timeout();
        test_reset_mid();
        test_en_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
